// File: rtl/ps2_scancode_rx_if.sv
// rtl/ps2_scancode_rx_if.sv - scan-code output bus of the PS/2 receiver
interface ps2_scancode_rx_if;
  logic [7:0] data_reg;
  logic       rx_valid;
  logic       break_o;
  logic       ext_o;
  logic       frame_err;

  modport master (
    output data_reg,
    output rx_valid,
    output break_o,
    output ext_o,
    output frame_err
  );

  modport slave (
    input data_reg,
    input rx_valid,
    input break_o,
    input ext_o,
    input frame_err
  );
endinterface

// File: rtl/ps2_scancode_rx.sv
// rtl/ps2_scancode_rx.sv - PS/2 keyboard frame receiver with E0/F0 prefix decoding
module ps2_scancode_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 10000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  ps2_scancode_rx_if.master bus
);

  localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [FLT_W-1:0] FLT_MAX = FLT_W'(FILTER_LEN - 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_s;
  logic                   dat_s;

  logic                   filt;
  logic                   filt_d;
  logic [FLT_W-1:0]       flt_cnt;
  logic                   fall;

  state_t                 state;
  logic [3:0]             bit_cnt;
  logic [TMO_W-1:0]       tmo;
  logic [9:0]             shreg;
  logic                   brk_pend;
  logic                   ext_pend;
  logic                   frame_good;

  logic [7:0]             data_q;
  logic                   rx_valid_q;
  logic                   break_q;
  logic                   ext_q;
  logic                   frame_err_q;

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];

  // Idle PS/2 lines are high, so the synchronisers reset to 1 to avoid a fake start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // Debounce ps2_clk: the filtered level only follows after FILTER_LEN disagreeing samples in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt    <= 1'b1;
      filt_d  <= 1'b1;
      flt_cnt <= '0;
    end else begin
      filt_d <= filt;
      if (clk_s != filt) begin
        if (flt_cnt == FLT_MAX) begin
          filt    <= clk_s;
          flt_cnt <= '0;
        end else begin
          flt_cnt <= flt_cnt + 1'b1;
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  assign fall = filt_d & ~filt;

  // Byte in shreg[7:0], parity in shreg[8], stop in shreg[9]; odd parity over byte+parity.
  assign frame_good = (^shreg[8:0]) & shreg[9];

  // Frame FSM: collects 10 bits after the start bit, validates, then folds prefixes into pend flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      tmo         <= '0;
      shreg       <= '0;
      brk_pend    <= 1'b0;
      ext_pend    <= 1'b0;
      data_q      <= '0;
      rx_valid_q  <= 1'b0;
      break_q     <= 1'b0;
      ext_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (fall && !dat_s) begin
            state   <= RECV;
            bit_cnt <= '0;
            tmo     <= '0;
          end
        end
        RECV: begin
          if (fall) begin
            shreg   <= {dat_s, shreg[9:1]};
            tmo     <= '0;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd9) begin
              state <= CHECK;
            end
          end else if (tmo == TMO_MAX) begin
            state       <= IDLE;
            frame_err_q <= 1'b1;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        CHECK: begin
          state <= IDLE;
          if (!frame_good) begin
            frame_err_q <= 1'b1;
            brk_pend    <= 1'b0;
            ext_pend    <= 1'b0;
          end else if (shreg[7:0] == 8'hF0) begin
            brk_pend <= 1'b1;
          end else if (shreg[7:0] == 8'hE0) begin
            ext_pend <= 1'b1;
          end else begin
            data_q     <= shreg[7:0];
            break_q    <= brk_pend;
            ext_q      <= ext_pend;
            rx_valid_q <= 1'b1;
            brk_pend   <= 1'b0;
            ext_pend   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_reg  = data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.break_o   = break_q;
  assign bus.ext_o     = ext_q;
  assign bus.frame_err = frame_err_q;

endmodule
